// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-stage control inputs and instruction-fetch request channel of pc_gen
// master: pc_gen side (drives fetch_valid/fetch_addr, PC and misalign status)
// slave: pipeline/imem side (drives stall, redirect, trap, fetch_ready)
interface pc_gen_if #(parameter int XLEN = 32);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_req;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_next_seq;
  logic            misalign_exc;
  logic [XLEN-1:0] bad_addr;
  modport master (
    input  stall, redirect_valid, redirect_target, trap_req, fetch_ready,
    output fetch_valid, fetch_addr, pc_out, pc_next_seq, misalign_exc, bad_addr
  );
  modport slave (
    output stall, redirect_valid, redirect_target, trap_req, fetch_ready,
    input  fetch_valid, fetch_addr, pc_out, pc_next_seq, misalign_exc, bad_addr
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with boot delay, trap/redirect/sequential next-PC select and misalign trap
// clk/rst: clock and synchronous active-high reset
// bus: stall/redirect/trap/fetch_ready in; fetch_valid/fetch_addr/pc_out/pc_next_seq/misalign_exc/bad_addr out
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              IALIGN       = 4,
  parameter int              BOOT_DELAY   = 2
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.master  bus
);
  typedef enum logic {BOOT, RUN} state_e;
  // BOOT leaves on the edge where the counter would reach BOOT_DELAY; delay 0 behaves like 1
  localparam logic [3:0] LAST = 4'(BOOT_DELAY == 0 ? 0 : BOOT_DELAY - 1);
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d, bad_q, bad_d;
  logic            mis_q, mis_d, misal, run;
  always_comb begin
    run = state_q == RUN;
    misal = bus.redirect_valid && (IALIGN == 4 ? |bus.redirect_target[1:0] : bus.redirect_target[0]);
    state_d = run || cnt_q == LAST ? RUN : BOOT;
    cnt_d = run ? cnt_q : cnt_q + 4'd1;
    mis_d = run && !bus.trap_req && misal;
    bad_d = mis_d ? bus.redirect_target : bad_q;
    pc_d = !run ? pc_q :
           bus.trap_req || misal ? TRAP_VECTOR :
           bus.redirect_valid ? bus.redirect_target :
           bus.fetch_ready && !bus.stall ? pc_q + XLEN'(IALIGN) : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      pc_q    <= RESET_VECTOR;
      bad_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      mis_q   <= mis_d;
    end
  end
  assign bus.fetch_valid  = state_q == RUN;
  assign bus.fetch_addr   = pc_q;
  assign bus.pc_out       = pc_q;
  assign bus.pc_next_seq  = pc_q + XLEN'(IALIGN);
  assign bus.misalign_exc = mis_q;
  assign bus.bad_addr     = bad_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed table-driven bench for pc_gen (IALIGN 4 main instance, IALIGN 2 companion)
module tb_pc_gen;
  logic clk = 0, rst = 1, stall = 0, rv = 0, trap = 0, rdy = 0;
  logic [31:0] tgt = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pc_gen_if #(.XLEN(32)) ia ();
  pc_gen_if #(.XLEN(32)) ib ();
  assign ia.stall = stall;
  assign ia.redirect_valid = rv;
  assign ia.redirect_target = tgt;
  assign ia.trap_req = trap;
  assign ia.fetch_ready = rdy;
  assign ib.stall = stall;
  assign ib.redirect_valid = rv;
  assign ib.redirect_target = tgt;
  assign ib.trap_req = trap;
  assign ib.fetch_ready = rdy;
  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .IALIGN(4), .BOOT_DELAY(2))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .IALIGN(2), .BOOT_DELAY(2))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  typedef struct {
    logic rst, stall, rv, trap, rdy;
    logic [31:0] tgt;
    logic v;
    logic [31:0] pc;
    logic mis;
    logic [31:0] bad;
    logic bchk;
    logic [31:0] bpc;
  } vec_t;
  vec_t tv[21];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, s, v, t, y, input logic [31:0] g);
    @(negedge clk);
    rst = r; stall = s; rv = v; trap = t; rdy = y; tgt = g;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic v, input logic [31:0] pc, input logic mis, input logic [31:0] bad);
    chk({tag, " fetch_valid"}, {31'b0, ia.fetch_valid}, {31'b0, v});
    chk({tag, " pc_out"}, ia.pc_out, pc);
    chk({tag, " fetch_addr"}, ia.fetch_addr, pc);
    chk({tag, " pc_next_seq"}, ia.pc_next_seq, pc + 32'd4);
    chk({tag, " misalign_exc"}, {31'b0, ia.misalign_exc}, {31'b0, mis});
    chk({tag, " bad_addr"}, ia.bad_addr, bad);
  endtask
  initial begin
    tv[0]  = '{1,0,0,0,1,32'h0,        0,32'h0,        0,32'h0,   0,32'h0};
    tv[1]  = '{1,0,0,0,1,32'h0,        0,32'h0,        0,32'h0,   0,32'h0};
    tv[2]  = '{0,0,0,1,1,32'h0,        0,32'h0,        0,32'h0,   0,32'h0};
    tv[3]  = '{0,0,0,1,1,32'h0,        1,32'h0,        0,32'h0,   0,32'h0};
    tv[4]  = '{0,0,0,0,1,32'h0,        1,32'h4,        0,32'h0,   0,32'h0};
    tv[5]  = '{0,0,0,0,1,32'h0,        1,32'h8,        0,32'h0,   0,32'h0};
    tv[6]  = '{0,0,0,0,1,32'h0,        1,32'hC,        0,32'h0,   0,32'h0};
    tv[7]  = '{0,0,0,0,1,32'h0,        1,32'h10,       0,32'h0,   0,32'h0};
    tv[8]  = '{0,0,0,0,0,32'h0,        1,32'h10,       0,32'h0,   0,32'h0};
    tv[9]  = '{0,0,0,0,0,32'h0,        1,32'h10,       0,32'h0,   0,32'h0};
    tv[10] = '{0,0,0,0,0,32'h0,        1,32'h10,       0,32'h0,   0,32'h0};
    tv[11] = '{0,1,0,0,1,32'h0,        1,32'h10,       0,32'h0,   0,32'h0};
    tv[12] = '{0,0,0,0,1,32'h0,        1,32'h14,       0,32'h0,   0,32'h0};
    tv[13] = '{0,1,1,0,0,32'h200,      1,32'h200,      0,32'h0,   0,32'h0};
    tv[14] = '{0,0,1,1,1,32'h300,      1,32'h100,      0,32'h0,   0,32'h0};
    tv[15] = '{0,0,1,0,0,32'h202,      1,32'h100,      1,32'h202, 1,32'h202};
    tv[16] = '{0,0,0,0,0,32'h0,        1,32'h100,      0,32'h202, 0,32'h0};
    tv[17] = '{0,0,0,0,1,32'h0,        1,32'h104,      0,32'h202, 0,32'h0};
    tv[18] = '{0,0,1,1,1,32'h203,      1,32'h100,      0,32'h202, 0,32'h0};
    tv[19] = '{0,0,1,0,0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0,32'h202, 0,32'h0};
    tv[20] = '{0,0,0,0,1,32'h0,        1,32'h0,        0,32'h202, 0,32'h0};
    for (int i = 0; i < 21; i++) begin
      step(tv[i].rst, tv[i].stall, tv[i].rv, tv[i].trap, tv[i].rdy, tv[i].tgt);
      chk_a($sformatf("vec%0d", i), tv[i].v, tv[i].pc, tv[i].mis, tv[i].bad);
      if (tv[i].bchk) begin
        chk($sformatf("vec%0d ialign2 pc_out", i), ib.pc_out, tv[i].bpc);
        chk($sformatf("vec%0d ialign2 misalign_exc", i), {31'b0, ib.misalign_exc}, 32'h0);
      end
    end
    step(0, 0, 1, 0, 0, 32'h48);
    chk_a("redir48", 1, 32'h48, 0, 32'h202);
    step(1, 0, 1, 0, 1, 32'h400);
    chk_a("midrst", 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0);
    chk_a("reboot1", 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0);
    chk_a("reboot2", 1, 32'h0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0);
    chk_a("reboot3", 1, 32'h4, 0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
